// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder.
// One full-adder cell plus a registered carry. The cell processes one operand
// bit per clock, LSB first. The adder captures a, b and c_in on the accepting
// edge and presents {c_out, sum} = a + b + c_in with a one-cycle done pulse.

// 1-bit full-adder cell feeding the serial datapath.
module serial_adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  // Plain sum / majority; kept as its own cell so the serial loop reads as
  // "one cell, one carry flop".
  always_comb begin
    s  = x ^ y ^ ci;
    co = (x & y) | (x & ci) | (y & ci);
  end

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] partial_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;

  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

  // The single adder cell always looks at the current LSBs and carry.
  serial_adder_fa u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (fa_sum),
    .co (fa_cout)
  );

  // Partial sum fills from the MSB side so that after WIDTH steps bit 0 holds
  // the first (LSB) result bit. A 1-bit adder has nothing to shift down.
  generate
    if (WIDTH == 1) begin : g_part_w1
      always_comb partial_nxt = fa_sum;
    end else begin : g_part_wn
      always_comb partial_nxt = {fa_sum, partial[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    accept   = (state == IDLE) && start;
    last_bit = (state == SHIFT) && (cnt == LAST_BIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start outside IDLE is simply not looked at.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_BIT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand shifters, carry and bit counter: load on accept, step in SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      partial <= '0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      carry   <= c_in;
      cnt     <= '0;
      partial <= '0;
    end else if (state == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      carry   <= fa_cout;
      cnt     <= cnt + 1'b1;
      partial <= partial_nxt;
    end
  end

  // Result registers only move on the final bit, so they hold through IDLE
  // and through the next operation until it completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else if (last_bit) begin
      sum_q   <= partial_nxt;
      c_out_q <= fa_cout;
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    busy  = (state == SHIFT);
    done  = (state == DONE);
    sum   = sum_q;
    c_out = c_out_q;
  end

endmodule
